// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: I/O write FSM encoding and default decode constants
// reused by every on-chip device decoder.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IO_IDLE  = 2'd0,
    IO_WRITE = 2'd1,
    IO_HOLD  = 2'd2
  } io_state_t;

  localparam logic [15:0] ROM_BASE_DEF = 16'h0000;
  localparam int          ROM_AW_DEF   = 12;
  localparam logic [7:0]  OUT_PORT_DEF = 8'h01;

  // True when addr falls in the 2^aw-byte window starting at base.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          aw);
    logic [15:0] mask;
    mask = 16'hFFFF << aw;
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer; every stage resets to RST_VAL.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 bus front end: strobe synchronizers, registered ROM read select and a
// captured output port with a one-cycle write pulse and write counter.
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE    = ROM_BASE_DEF,
  parameter int          ROM_AW      = ROM_AW_DEF,
  parameter logic [7:0]  OUT_PORT    = OUT_PORT_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        pll0_100MHz,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  output logic        rom_cs,
  output logic [7:0]  out_port_data,
  output logic        out_port_wr,
  output logic [7:0]  out_port_wr_cnt
);

  logic mreq_s, iorq_s, rd_s, wr_s, m1_s;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mreq (
    .clk(pll0_100MHz), .rst(reset), .d(cpu_mreq_n), .q(mreq_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iorq (
    .clk(pll0_100MHz), .rst(reset), .d(cpu_iorq_n), .q(iorq_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk(pll0_100MHz), .rst(reset), .d(cpu_rd_n), .q(rd_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk(pll0_100MHz), .rst(reset), .d(cpu_wr_n), .q(wr_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_m1 (
    .clk(pll0_100MHz), .rst(reset), .d(cpu_m1_n), .q(m1_s));

  // Stage p0: address decode qualified by the synchronized read strobes.
  logic rom_hit_p0;

  always_ff @(posedge pll0_100MHz) begin
    if (reset) begin
      rom_hit_p0 <= 1'b0;
      rom_cs     <= 1'b0;
    end else begin
      rom_hit_p0 <= !mreq_s && !rd_s && in_window(cpu_addr, ROM_BASE, ROM_AW);
      rom_cs     <= rom_hit_p0;
    end
  end

  // Synchronizer outputs carry their reset value until SYNC_STAGES edges have
  // sampled the real pins; settle_p0 keeps IO_HOLD from mistaking that for idle.
  io_state_t              io_state;
  logic [SYNC_STAGES-1:0] settle_p0;
  logic                   port_hit_p0;
  logic [7:0]             dout_p0;

  always_ff @(posedge pll0_100MHz) begin
    if (reset) begin
      io_state        <= IO_HOLD;
      settle_p0       <= '0;
      port_hit_p0     <= 1'b0;
      dout_p0         <= 8'h00;
      out_port_data   <= 8'h00;
      out_port_wr     <= 1'b0;
      out_port_wr_cnt <= 8'h00;
    end else begin
      settle_p0   <= {settle_p0[SYNC_STAGES-2:0], 1'b1};
      out_port_wr <= 1'b0;
      case (io_state)
        IO_IDLE: begin
          if (!iorq_s && !wr_s && m1_s) begin
            io_state    <= IO_WRITE;
            port_hit_p0 <= (cpu_addr[7:0] == OUT_PORT);
            dout_p0     <= cpu_dout;
          end
        end
        // Stage p1: commit the captured write.
        IO_WRITE: begin
          io_state <= IO_HOLD;
          if (port_hit_p0) begin
            out_port_data   <= dout_p0;
            out_port_wr     <= 1'b1;
            out_port_wr_cnt <= out_port_wr_cnt + 8'd1;
          end
        end
        IO_HOLD: begin
          if ((iorq_s || wr_s) && settle_p0[SYNC_STAGES-1]) io_state <= IO_IDLE;
        end
        default: io_state <= IO_HOLD;
      endcase
    end
  end

endmodule

// File: doc/z80_bus_ctrl.md
# z80_bus_ctrl

Z80 bus-cycle front end running in the 100 MHz FPGA domain. Synchronizes the asynchronous Z80 control strobes, decodes memory reads in the ROM window into the registered `rom_cs` that drives the CPU data-in mux, and captures Z80 I/O writes to one output port into a held register with a single-cycle write pulse. It sits directly upstream of the CPU data-in mux, between the Z80 pins and every on-chip device select.

## Interface
Parameters:
- `ROM_BASE`, 16'h0000: ROM window base address, aligned to the window size.
- `ROM_AW`, 12: ROM address width. The window is 2^ROM_AW bytes.
- `OUT_PORT`, 8'h01: I/O address, on `cpu_addr[7:0]`, of the output port.
- `SYNC_STAGES`, 2: flip-flop stages per strobe synchronizer. Legal values are 2 or more.

Ports:
- `pll0_100MHz`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cpu_addr`, in, 16: Z80 address bus.
- `cpu_dout`, in, 8: Z80 data-out bus.
- `cpu_mreq_n`, `cpu_iorq_n`, `cpu_rd_n`, `cpu_wr_n`, `cpu_m1_n`, in, 1 each: Z80 strobes, asynchronous and active-low.
- `rom_cs`, out, 1: registered ROM read select, feeding the data-in mux.
- `out_port_data`, out, 8: last value written to `OUT_PORT`.
- `out_port_wr`, out, 1: one-cycle pulse per accepted port write.
- `out_port_wr_cnt`, out, 8: count of accepted port writes. Wraps from 8'hFF to 8'h00.

## Operation
- **Synchronizers.** Each strobe passes through a `SYNC_STAGES`-deep chain. All chain stages reset to 1 (inactive). The synchronized outputs are `mreq_s`, `iorq_s`, `rd_s`, `wr_s` and `m1_s`.
- **Unsynchronized buses.** Address and data are not synchronized. They are sampled only while a qualifying synchronized strobe is low, because Z80 timing guarantees both buses are stable by then.
- **ROM decode.** `rom_cs` is set to `!mreq_s && !rd_s && (cpu_addr[15:ROM_AW] == ROM_BASE[15:ROM_AW])`, registered every cycle.
  - Refresh cycles (MREQ low, RD high) never assert it.
  - Memory writes never assert it.
  - Addresses outside the window never assert it.
- **I/O write FSM.** Three states: `IO_IDLE`, `IO_WRITE`, `IO_HOLD`.
  - `IO_IDLE` to `IO_WRITE` when `!iorq_s && !wr_s && m1_s`. Interrupt acknowledge (IORQ and M1 both low) never qualifies.
  - `IO_WRITE` always moves to `IO_HOLD` after one cycle. On entry to `IO_WRITE`, if `cpu_addr[7:0] == OUT_PORT`:
    - `out_port_data` is loaded from `cpu_dout`;
    - `out_port_wr` is 1 for that cycle;
    - `out_port_wr_cnt` increments.
  - Writes to any other port pass through `IO_WRITE` with no output change.
  - `IO_HOLD` to `IO_IDLE` when `iorq_s || wr_s` is 1. This gives exactly one capture per bus cycle, whatever the cycle's length.
- **Reset values.**
  - `rom_cs` = 0, `out_port_data` = 8'h00, `out_port_wr` = 0, `out_port_wr_cnt` = 0.
  - The FSM resets to `IO_HOLD`, not `IO_IDLE`. A write already in progress when reset releases is therefore discarded, and capture resumes only after the strobes have been seen inactive.
- **Simultaneous strobes.** MREQ and IORQ are mutually exclusive on a legal Z80. If both are seen low, ROM decode and the FSM act independently, and neither suppresses the other.

## Timing
Edge 0 is the first clock edge that samples the relevant raw strobe(s) at their new level. S is `SYNC_STAGES`.
- `rom_cs` rises at edge S+1 after MREQ and RD are both low. It falls at edge S+1 after either strobe rises. With S=2 that is 30 ns each way, well within a Z80 read at up to 8 MHz.
- `out_port_wr` is high for exactly one cycle, starting at edge S+1 after IORQ and WR are both low.
- `out_port_data` and `out_port_wr_cnt` change on the same edge `out_port_wr` rises, and hold until the next accepted write.
- Back-to-back OUT instructions each produce one pulse, provided the strobes are high for at least S+1 cycles between them. Z80 timing always satisfies this at 100 MHz.
- When `reset` is asserted, all outputs and state take their reset values on the next edge, whatever the current state.

## Structure
- Shared package `z80_bus_pkg`:
  - FSM state type and encoding (`IO_IDLE`, `IO_WRITE`, `IO_HOLD`);
  - default constants for the ROM base, ROM width and output port number, so other decoders reuse them.
- Sub-module `sync_bit`: a parameterized N-stage single-bit synchronizer with a reset value parameter. It is instantiated five times.

## Test plan
- Read at 16'h0123 (MREQ/RD low for 40 cycles) -> `rom_cs` 0→1 at edge 3, 1→0 three edges after RD rises. Repeat at 16'h1000 -> `rom_cs` stays 0.
- OUT (01h),8'hA5 -> one-cycle `out_port_wr` at edge 3, `out_port_data` = 8'hA5, `out_port_wr_cnt` = 1. OUT (02h),8'h5A -> no pulse, data and count unchanged.
- Interrupt acknowledge (M1 and IORQ low, WR high) plus a refresh cycle (MREQ low, RD high) -> `rom_cs` stays 0 and `out_port_wr` stays 0 throughout.
- Reset asserted mid-write with IORQ/WR held low, then released -> no pulse until the strobes rise; the next OUT (01h),8'h3C is captured normally.
- 256 consecutive OUT (01h) writes with 5-cycle gaps -> 256 pulses, `out_port_wr_cnt` wraps to 8'h00, `out_port_data` equals the last value written.
